// File: rtl/hamming_pad_decode.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_pad_decode
//  Brief    : SECDED Hamming decoder. It re-interleaves a received payload
//             and its separately carried check bits into one codeword, then
//             computes the syndrome and overall parity. Corrected data,
//             raw data, fault position and error count are registered.
//  Revision : 1.0 - initial release
// ============================================================================

// Helper package. It holds the check-bit count function, so the port list
// can size itself from DATA_WIDTH alone.
package hamming_pad_decode_pkg;
    // Smallest p with 2^p >= dw + p + 1.
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) begin
            p = p + 1;
        end
        return p;
    endfunction
endpackage

module hamming_pad_decode #(
    parameter  int DATA_WIDTH  = 8,
    localparam int P           = hamming_pad_decode_pkg::calc_p(DATA_WIDTH),
    localparam int CODE_BITS   = P + 1,
    localparam int CODED_WIDTH = DATA_WIDTH + CODE_BITS,
    localparam int ADDR_WIDTH  = $clog2(CODED_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [DATA_WIDTH-1:0]  data_in_i,
    input  logic [CODE_BITS-1:0]   pad_bits_i,
    output logic [CODED_WIDTH-1:0] coded_o,
    output logic [DATA_WIDTH-1:0]  raw_data_o,
    output logic [DATA_WIDTH-1:0]  data_out_o,
    output logic [ADDR_WIDTH-1:0]  fault_location_o,
    output logic [1:0]             num_errors_o
);

    // Error-count encodings. The value 2'd3 is never produced.
    localparam logic [1:0] C_NE_NONE      = 2'd0;
    localparam logic [1:0] C_NE_CORRECTED = 2'd1;
    localparam logic [1:0] C_NE_FATAL     = 2'd2;

    logic [CODED_WIDTH-1:0] coded_w;
    logic [CODED_WIDTH-1:0] flip_mask_w;
    logic [CODED_WIDTH-1:0] corrected_w;
    logic [P-1:0]           syndrome_w;
    logic                   parity_w;
    logic                   single_w;

    logic [DATA_WIDTH-1:0]  raw_data_d;
    logic [DATA_WIDTH-1:0]  data_out_d;
    logic [ADDR_WIDTH-1:0]  fault_location_d;
    logic [1:0]             num_errors_d;

    logic [DATA_WIDTH-1:0]  raw_data_q;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic [ADDR_WIDTH-1:0]  fault_location_q;
    logic [1:0]             num_errors_q;

    // Interleave: position 0 takes the overall parity, powers of two take
    // the Hamming check bits, and all other positions take the payload in order.
    always_comb begin
        int j;
        int k;
        j       = 0;
        k       = 0;
        coded_w = '0;
        coded_w[0] = pad_bits_i[P];
        for (int i = 1; i < CODED_WIDTH; i++) begin
            if ((i & (i - 1)) == 0) begin
                coded_w[i] = pad_bits_i[k];
                k = k + 1;
            end else begin
                coded_w[i] = data_in_i[j];
                j = j + 1;
            end
        end
    end

    assign coded_o = coded_w;

    // Syndrome is the XOR of the indices of the set bits. Overall parity
    // spans the full codeword, including position 0.
    always_comb begin
        syndrome_w = '0;
        parity_w   = 1'b0;
        for (int i = 0; i < CODED_WIDTH; i++) begin
            parity_w = parity_w ^ coded_w[i];
        end
        for (int i = 1; i < CODED_WIDTH; i++) begin
            if (coded_w[i]) begin
                syndrome_w = syndrome_w ^ P'(i);
            end
        end
    end

    // A single error needs odd overall parity and a syndrome that names a
    // real position. A syndrome past the end of the codeword can only come
    // from a multi-bit error.
    assign single_w = parity_w && (int'(syndrome_w) < CODED_WIDTH);

    // Build a one-hot flip mask at the syndrome position. If the syndrome is
    // 0, only the overall-parity bit flips, so the payload is unaffected.
    always_comb begin
        flip_mask_w = '0;
        for (int i = 0; i < CODED_WIDTH; i++) begin
            flip_mask_w[i] = single_w && (syndrome_w == P'(i));
        end
    end

    assign corrected_w = coded_w ^ flip_mask_w;

    // Classify the error and extract the payload, both before and after
    // correction, using the inverse of the interleave mapping.
    always_comb begin
        int j;
        j                = 0;
        raw_data_d       = '0;
        data_out_d       = '0;
        fault_location_d = '0;
        num_errors_d     = C_NE_NONE;

        for (int i = 1; i < CODED_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                raw_data_d[j] = coded_w[i];
                data_out_d[j] = corrected_w[i];
                j = j + 1;
            end
        end

        if (single_w) begin
            num_errors_d     = C_NE_CORRECTED;
            fault_location_d = ADDR_WIDTH'(syndrome_w);
        end else if (parity_w || (syndrome_w != '0)) begin
            num_errors_d     = C_NE_FATAL;
        end
    end

    // Output registers. Reset clears them asynchronously. No other state
    // exists, so the first edge after reset release decodes fresh inputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            raw_data_q       <= '0;
            data_out_q       <= '0;
            fault_location_q <= '0;
            num_errors_q     <= C_NE_NONE;
        end else begin
            raw_data_q       <= raw_data_d;
            data_out_q       <= data_out_d;
            fault_location_q <= fault_location_d;
            num_errors_q     <= num_errors_d;
        end
    end

    assign raw_data_o       = raw_data_q;
    assign data_out_o       = data_out_q;
    assign fault_location_o = fault_location_q;
    assign num_errors_o     = num_errors_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_pad_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hamming_pad_decode
//  Brief    : Scoreboard bench for hamming_pad_decode (DATA_WIDTH = 8).
//             The driver pushes hand-computed expectations into a queue,
//             and the monitor pops and compares them one cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_pad_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic [4:0]  pad;
    logic [12:0] coded;
    logic [7:0]  raw;
    logic [7:0]  dout;
    logic [3:0]  loc;
    logic [1:0]  nerr;

    typedef struct {
        string      name;
        logic [7:0] raw;
        logic [7:0] dout;
        logic [3:0] loc;
        logic [1:0] ne;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    hamming_pad_decode #(.DATA_WIDTH(8)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .data_in_i        (data_in),
        .pad_bits_i       (pad),
        .coded_o          (coded),
        .raw_data_o       (raw),
        .data_out_o       (dout),
        .fault_location_o (loc),
        .num_errors_o     (nerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive the inputs now and push the expected result for the next edge.
    task automatic drive_push(input string name, input logic [7:0] d, input logic [4:0] p,
                              input logic [7:0] e_raw, input logic [7:0] e_dout,
                              input logic [3:0] e_loc, input logic [1:0] e_ne);
        exp_t e;
        data_in = d;
        pad     = p;
        e.name = name; e.raw = e_raw; e.dout = e_dout; e.loc = e_loc; e.ne = e_ne;
        q.push_back(e);
    endtask

    task automatic send(input string name, input logic [7:0] d, input logic [4:0] p,
                        input logic [7:0] e_raw, input logic [7:0] e_dout,
                        input logic [3:0] e_loc, input logic [1:0] e_ne);
        @(negedge clk);
        drive_push(name, d, p, e_raw, e_dout, e_loc, e_ne);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending %0d expected 0", q.size());
        end
    endtask

    // Monitor: compare the registered outputs shortly after each edge
    // against the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".raw"},  {24'd0, raw},  {24'd0, e.raw});
            chk({e.name, ".dout"}, {24'd0, dout}, {24'd0, e.dout});
            chk({e.name, ".loc"},  {28'd0, loc},  {28'd0, e.loc});
            chk({e.name, ".nerr"}, {30'd0, nerr}, {30'd0, e.ne});
        end
    end

    // Single-bit flips of the reference word (data 0xA5, pad 0x03), one per
    // codeword position 0..12: {data_in, pad}.
    logic [7:0] flip_d [13] = '{8'hA5, 8'hA5, 8'hA5, 8'hA4, 8'hA5, 8'hA7, 8'hA1,
                                8'hAD, 8'hA5, 8'hB5, 8'h85, 8'hE5, 8'h25};
    logic [4:0] flip_p [13] = '{5'h13, 5'h02, 5'h01, 5'h03, 5'h07, 5'h03, 5'h03,
                                5'h03, 5'h0B, 5'h03, 5'h03, 5'h03, 5'h03};

    initial begin
        rst_n   = 1'b0;
        data_in = 8'h5A;
        pad     = 5'h1F;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.raw",  {24'd0, raw},  32'h0);
        chk("reset.dout", {24'd0, dout}, 32'h0);
        chk("reset.loc",  {28'd0, loc},  32'h0);
        chk("reset.nerr", {30'd0, nerr}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Clean reference word. Codeword set bits are at positions
        // 1, 2 (check bits), 3, 6, 10, 12 (data ones), which gives 0x144E.
        send("clean", 8'hA5, 5'h03, 8'hA5, 8'hA5, 4'd0, 2'd0);
        #1;
        chk("coded_clean", {19'd0, coded}, 32'h0000144E);

        send("data_err6", 8'hA1, 5'h03, 8'hA1, 8'hA5, 4'd6, 2'd1);
        send("chk_err4",  8'hA5, 5'h07, 8'hA5, 8'hA5, 4'd4, 2'd1);
        send("ovp_err0",  8'hA5, 5'h13, 8'hA5, 8'hA5, 4'd0, 2'd1);
        send("double",    8'hA0, 5'h03, 8'hA0, 8'hA0, 4'd0, 2'd2);
        // Flips at positions 1, 2 and 12 give syndrome 15 (beyond the
        // codeword) with odd parity, so the word is uncorrectable.
        send("bad_synd",  8'h25, 5'h00, 8'h25, 8'h25, 4'd0, 2'd2);

        // Back-to-back streaming of every single-bit flip.
        for (int i = 0; i < 13; i++) begin
            send($sformatf("flip%0d", i), flip_d[i], flip_p[i],
                 flip_d[i], 8'hA5, 4'(i), 2'd1);
        end
        send("clean2", 8'hA5, 5'h03, 8'hA5, 8'hA5, 4'd0, 2'd0);
        drain();

        // Load a non-zero result, then assert reset mid-cycle, away from any edge.
        send("pre_reset", 8'hA1, 5'h03, 8'hA1, 8'hA5, 4'd6, 2'd1);
        drain();
        @(posedge clk);
        #3;
        data_in = 8'h3C;
        pad     = 5'h15;
        rst_n   = 1'b0;
        #1;
        chk("async_rst.raw",  {24'd0, raw},  32'h0);
        chk("async_rst.dout", {24'd0, dout}, 32'h0);
        chk("async_rst.loc",  {28'd0, loc},  32'h0);
        chk("async_rst.nerr", {30'd0, nerr}, 32'h0);

        // Release reset mid-stream. The very next edge decodes the new inputs.
        @(negedge clk);
        rst_n = 1'b1;
        drive_push("post_rst", 8'hAD, 5'h03, 8'hAD, 8'hA5, 4'd7, 2'd1);
        send("post_rst2", 8'hA5, 5'h03, 8'hA5, 8'hA5, 4'd0, 2'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
